// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding a combinational instruction ROM.
// Selects sequential/branch/jump next PC and stops on halt opcode or program limit.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT    = 32'h0000_0070,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic [5:0]  opcode,
    input  logic        branch_taken,
    input  logic [31:0] imm_signed,
    input  logic        jump,
    input  logic [31:0] jmp_signed,
    output logic [31:0] pcOut,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] next_pc;
    logic        is_halt_op;
    logic        unused_bits;

    // Upper bits of the offsets fall outside the word-shifted arithmetic.
    assign unused_bits = ^{jmp_signed[31:26], imm_signed[31:30]};

    assign pc_plus4    = pcOut + 32'd4;
    assign is_halt_op  = (opcode == HALT_OPCODE);
    assign fetch_valid = (state == ST_RUN) && !stall && (pcOut < PC_LIMIT) && !is_halt_op;
    assign halted      = (state == ST_HALT);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jmp_signed[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + {imm_signed[29:0], 2'b00};
        end
        next_pc[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pcOut       <= RESET_PC_ALIGNED;
            instr_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pcOut <= RESET_PC_ALIGNED;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (fetch_valid) begin
                            // A target past the program is still loaded, then fetch stops there.
                            instr_count <= instr_count + 32'd1;
                            pcOut       <= next_pc;
                            if (next_pc >= PC_LIMIT) begin
                                state <= ST_HALT;
                            end
                        end else begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed test-plan steps followed by random control traffic, checked against
// a cycle-level reference model of the fetch rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_LIMIT    = 32'h0000_0070;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic [5:0]  opcode;
    logic        branch_taken;
    logic [31:0] imm_signed;
    logic        jump;
    logic [31:0] jmp_signed;
    logic [31:0] pcOut;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] instr_count;

    int unsigned checks;
    int unsigned errors;

    // Reference model state
    logic        m_running;
    logic        m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    pc_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .PC_LIMIT   (PC_LIMIT),
        .HALT_OPCODE(HALT_OPCODE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .opcode      (opcode),
        .branch_taken(branch_taken),
        .imm_signed  (imm_signed),
        .jump        (jump),
        .jmp_signed  (jmp_signed),
        .pcOut       (pcOut),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fv();
        return m_running && !stall && (m_pc < PC_LIMIT) && (opcode != HALT_OPCODE);
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        logic [31:0] target;
        if (rst) begin
            m_running = 1'b0;
            m_halted  = 1'b0;
            m_pc      = RESET_PC;
            m_count   = 32'd0;
        end else if (!m_running && !m_halted) begin
            if (start) begin
                m_running = 1'b1;
                m_pc      = RESET_PC;
            end
        end else if (m_running && !stall) begin
            if (model_fv()) begin
                m_count = m_count + 32'd1;
                if (jump)
                    target = ((m_pc + 32'd4) & 32'hF000_0000) + ((jmp_signed & 32'h03FF_FFFF) * 32'd4);
                else if (branch_taken)
                    target = m_pc + 32'd4 + imm_signed * 32'd4;
                else
                    target = m_pc + 32'd4;
                target = target & 32'hFFFF_FFFC;
                m_pc = target;
                if (target >= PC_LIMIT) begin
                    m_running = 1'b0;
                    m_halted  = 1'b1;
                end
            end else begin
                m_running = 1'b0;
                m_halted  = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic a_rst, input logic a_start, input logic a_stall,
                        input logic [5:0] a_op, input logic a_br, input logic [31:0] a_imm,
                        input logic a_jump, input logic [31:0] a_jidx);
        @(negedge clk);
        rst          = a_rst;
        start        = a_start;
        stall        = a_stall;
        opcode       = a_op;
        branch_taken = a_br;
        imm_signed   = a_imm;
        jump         = a_jump;
        jmp_signed   = a_jidx;
        #1;
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, model_fv()});
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        @(posedge clk);
        model_edge();
        #1;
        chk("pcOut", pcOut, m_pc);
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("instr_count", instr_count, m_count);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 6'd0, 1'b1, 32'd5, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic advance_to(input logic [31:0] target);
        for (int i = 0; i < 64 && m_pc != target; i++) nop();
        chk("advance_reached", m_pc, target);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_running = 1'b0;
        m_halted  = 1'b0;
        m_pc      = RESET_PC;
        m_count   = 32'd0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; opcode = 6'd0;
        branch_taken = 1'b0; imm_signed = 32'd0; jump = 1'b0; jmp_signed = 32'd0;

        // Reset state
        do_reset();
        chk("reset_pc", pcOut, 32'h0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);

        // Sequential run to the program limit
        do_start();
        chk("start_pc", pcOut, 32'h0);
        for (int i = 0; i < 40; i++) nop();
        chk("seq_end_pc", pcOut, 32'h70);
        chk("seq_end_halted", {31'd0, halted}, 32'd1);
        chk("seq_end_count", instr_count, 32'd28);

        // Stall for three cycles at 0x10
        do_reset();
        do_start();
        advance_to(32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 32'd9, 1'b1, 32'd3);
            chk("stall_pc_hold", pcOut, 32'h10);
            chk("stall_count_hold", instr_count, 32'd4);
        end
        nop();
        chk("stall_release_pc", pcOut, 32'h14);

        // Forward and backward branches
        do_reset();
        do_start();
        advance_to(32'h08);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0003, 1'b0, 32'd0);
        chk("branch_fwd_pc", pcOut, 32'h18);
        advance_to(32'h20);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        chk("branch_back_pc", pcOut, 32'h14);

        // Jump wins over branch
        do_reset();
        do_start();
        advance_to(32'h0C);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'd5, 1'b1, 32'd2);
        chk("jump_prio_pc", pcOut, 32'h08);

        // Halt opcode at 0x30, start ignored, reset recovers
        advance_to(32'h30);
        @(negedge clk);
        opcode = HALT_OPCODE;
        #1;
        chk("haltop_fv", {31'd0, fetch_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, HALT_OPCODE, 1'b1, 32'd2, 1'b1, 32'd1);
        chk("haltop_halted", {31'd0, halted}, 32'd1);
        chk("haltop_pc", pcOut, 32'h30);
        step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nop();
        chk("halt_start_ignored_pc", pcOut, 32'h30);
        chk("halt_start_ignored_halted", {31'd0, halted}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("halt_reset_pc", pcOut, 32'h0);
        chk("halt_reset_count", instr_count, 32'd0);
        chk("halt_reset_halted", {31'd0, halted}, 32'd0);

        // Random control traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst, r_start, r_stall, r_br, r_jump;
            logic [5:0]  r_op;
            logic [31:0] r_imm, r_jidx;
            r_rst   = ($urandom_range(0, 99) < 2);
            r_start = ($urandom_range(0, 99) < 20);
            r_stall = ($urandom_range(0, 99) < 25);
            r_op    = ($urandom_range(0, 99) < 3) ? HALT_OPCODE : 6'($urandom_range(0, 62));
            r_br    = ($urandom_range(0, 99) < 20);
            r_imm   = 32'($urandom_range(0, 10)) - 32'd5;
            r_jump  = ($urandom_range(0, 99) < 10);
            r_jidx  = {6'($urandom), 26'($urandom_range(0, 31))};
            step(r_rst, r_start, r_stall, r_op, r_br, r_imm, r_jump, r_jidx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
